// File: rtl/mesi_bus_pkg.sv
// rtl/mesi_bus_pkg.sv - shared MESI bus types for the snoop request dispatcher
package mesi_bus_pkg;

  localparam int NUM_CORES_DEF = 4;
  localparam int CID_W_DEF     = $clog2(NUM_CORES_DEF);

  typedef enum logic [1:0] {
    BUS_RD    = 2'b00,
    BUS_RDX   = 2'b01,
    BUS_UPGR  = 2'b10,
    BUS_FLUSH = 2'b11
  } bus_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_SNOOP,
    ST_RESP
  } dispatch_state_e;

  typedef struct packed {
    logic [CID_W_DEF-1:0] core_id;
    bus_op_e              op;
  } bus_req_t;

endpackage

// File: rtl/snoop_req_dispatcher_if.sv
// rtl/snoop_req_dispatcher_if.sv - FIFO, snoop and response signals; resp_timeout exists only with SNOOP_TIMEOUT_EN
interface snoop_req_dispatcher_if #(
  parameter int NUM_CORES = mesi_bus_pkg::NUM_CORES_DEF,
  parameter int CID_W     = $clog2(NUM_CORES),
  parameter int REQ_W     = CID_W + 2
);
  logic                 fifo_empty;
  logic [REQ_W-1:0]     fifo_data;
  logic                 fifo_rd_en;
  logic [NUM_CORES-1:0] snoop_valid;
  logic [1:0]           snoop_op;
  logic [NUM_CORES-1:0] snoop_ready;
  logic [NUM_CORES-1:0] snoop_shared;
  logic [NUM_CORES-1:0] snoop_dirty;
  logic                 resp_valid;
  logic [CID_W-1:0]     resp_core;
  logic                 resp_shared;
  logic                 resp_dirty;
  logic                 resp_ack;
  logic                 busy;
`ifdef SNOOP_TIMEOUT_EN
  logic                 resp_timeout;

  modport master (
    input  fifo_empty, fifo_data, snoop_ready, snoop_shared, snoop_dirty, resp_ack,
    output fifo_rd_en, snoop_valid, snoop_op, resp_valid, resp_core, resp_shared,
           resp_dirty, busy, resp_timeout
  );
  modport slave (
    output fifo_empty, fifo_data, snoop_ready, snoop_shared, snoop_dirty, resp_ack,
    input  fifo_rd_en, snoop_valid, snoop_op, resp_valid, resp_core, resp_shared,
           resp_dirty, busy, resp_timeout
  );
`else
  modport master (
    input  fifo_empty, fifo_data, snoop_ready, snoop_shared, snoop_dirty, resp_ack,
    output fifo_rd_en, snoop_valid, snoop_op, resp_valid, resp_core, resp_shared,
           resp_dirty, busy
  );
  modport slave (
    output fifo_empty, fifo_data, snoop_ready, snoop_shared, snoop_dirty, resp_ack,
    input  fifo_rd_en, snoop_valid, snoop_op, resp_valid, resp_core, resp_shared,
           resp_dirty, busy
  );
`endif
endinterface

// File: rtl/snoop_req_dispatcher_snoop_collector.sv
// rtl/snoop_req_dispatcher_snoop_collector.sv - pending-mask tracking and shared/dirty accumulation for one snoop round
module snoop_collector #(
  parameter int NUM_CORES = 4,
  parameter int CID_W     = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CID_W-1:0]     load_core,
  input  logic                 load_flush,
  input  logic                 active,
  input  logic                 upgr,
  input  logic [NUM_CORES-1:0] snoop_ready,
  input  logic [NUM_CORES-1:0] snoop_shared,
  input  logic [NUM_CORES-1:0] snoop_dirty,
  output logic [NUM_CORES-1:0] pending,
  output logic                 shared_nx,
  output logic                 dirty_nx,
  output logic                 all_done
);
  localparam logic [NUM_CORES-1:0] ONE = {{(NUM_CORES-1){1'b0}}, 1'b1};

  logic [NUM_CORES-1:0] hits;
  logic [NUM_CORES-1:0] pending_nx;
  logic                 acc_shared;
  logic                 acc_dirty;

  // Responses on bits no longer pending (or the requester) never count.
  assign hits       = pending & snoop_ready;
  assign pending_nx = pending & ~hits;
  assign shared_nx  = acc_shared | (|(hits & snoop_shared));
  assign dirty_nx   = acc_dirty | (!upgr && (|(hits & snoop_dirty)));
  assign all_done   = (pending_nx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      acc_shared <= 1'b0;
      acc_dirty  <= 1'b0;
    end else if (load) begin
      pending    <= load_flush ? '0 : ~(ONE << load_core);
      acc_shared <= 1'b0;
      acc_dirty  <= 1'b0;
    end else if (active) begin
      pending    <= pending_nx;
      acc_shared <= shared_nx;
      acc_dirty  <= dirty_nx;
    end
  end

endmodule

// File: rtl/snoop_req_dispatcher.sv
// rtl/snoop_req_dispatcher.sv - pops bus requests, broadcasts snoops, returns aggregated shared/dirty; SNOOP_TIMEOUT_EN adds a snoop wait limit
module snoop_req_dispatcher
  import mesi_bus_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int CID_W     = $clog2(NUM_CORES),
  parameter int REQ_W     = CID_W + 2,
  parameter int TIMEOUT   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  snoop_req_dispatcher_if.master bus
);
  dispatch_state_e      state;
  logic [CID_W-1:0]     req_core;
  bus_op_e              req_op;
  logic [NUM_CORES-1:0] pending;
  logic                 shared_nx;
  logic                 dirty_nx;
  logic                 all_done;
  logic                 col_load;
  logic                 col_active;
  logic                 upgr;

  assign col_load   = (state == ST_LATCH);
  assign col_active = (state == ST_SNOOP);
  assign upgr       = (req_op == BUS_UPGR);

  snoop_collector #(
    .NUM_CORES (NUM_CORES),
    .CID_W     (CID_W)
  ) u_collector (
    .clk          (clk),
    .rst          (rst),
    .load         (col_load),
    .load_core    (bus.fifo_data[REQ_W-1:2]),
    .load_flush   (bus.fifo_data[1:0] == BUS_FLUSH),
    .active       (col_active),
    .upgr         (upgr),
    .snoop_ready  (bus.snoop_ready),
    .snoop_shared (bus.snoop_shared),
    .snoop_dirty  (bus.snoop_dirty),
    .pending      (pending),
    .shared_nx    (shared_nx),
    .dirty_nx     (dirty_nx),
    .all_done     (all_done)
  );

  // After a timeout the mask still holds the silent cores, so gate it to SNOOP.
  assign bus.snoop_valid = col_active ? pending : '0;

`ifdef SNOOP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      req_core        <= '0;
      req_op          <= BUS_RD;
      bus.fifo_rd_en  <= 1'b0;
      bus.snoop_op    <= 2'b00;
      bus.resp_valid  <= 1'b0;
      bus.resp_core   <= '0;
      bus.resp_shared <= 1'b0;
      bus.resp_dirty  <= 1'b0;
      bus.busy        <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
      wait_cnt         <= '0;
      bus.resp_timeout <= 1'b0;
`endif
    end else begin
      bus.fifo_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.fifo_empty) begin
            state          <= ST_POP;
            bus.fifo_rd_en <= 1'b1;
            bus.busy       <= 1'b1;
          end
        end
        ST_POP: state <= ST_LATCH;
        // FIFO output is registered, so the popped entry is visible only now.
        ST_LATCH: begin
          req_core <= bus.fifo_data[REQ_W-1:2];
          req_op   <= bus_op_e'(bus.fifo_data[1:0]);
          if (bus.fifo_data[1:0] == BUS_FLUSH) begin
            state           <= ST_RESP;
            bus.resp_valid  <= 1'b1;
            bus.resp_core   <= bus.fifo_data[REQ_W-1:2];
            bus.resp_shared <= 1'b0;
            bus.resp_dirty  <= 1'b0;
          end else begin
            state        <= ST_SNOOP;
            bus.snoop_op <= bus.fifo_data[1:0];
`ifdef SNOOP_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
          end
        end
        ST_SNOOP: begin
`ifdef SNOOP_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
`endif
          if (all_done) begin
            state           <= ST_RESP;
            bus.snoop_op    <= 2'b00;
            bus.resp_valid  <= 1'b1;
            bus.resp_core   <= req_core;
            bus.resp_shared <= shared_nx;
            bus.resp_dirty  <= dirty_nx;
          end
`ifdef SNOOP_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state            <= ST_RESP;
            bus.snoop_op     <= 2'b00;
            bus.resp_valid   <= 1'b1;
            bus.resp_core    <= req_core;
            bus.resp_shared  <= shared_nx;
            bus.resp_dirty   <= dirty_nx;
            bus.resp_timeout <= 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (bus.resp_ack) begin
            state           <= ST_IDLE;
            bus.resp_valid  <= 1'b0;
            bus.resp_core   <= '0;
            bus.resp_shared <= 1'b0;
            bus.resp_dirty  <= 1'b0;
            bus.busy        <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
            bus.resp_timeout <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_req_dispatcher.sv
// tb/tb_snoop_req_dispatcher.sv - self-checking bench for snoop_req_dispatcher (SNOOP_TIMEOUT_EN adds the timeout scenario)
module tb_snoop_req_dispatcher;
  import mesi_bus_pkg::*;

  localparam int NC = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  snoop_req_dispatcher_if #(.NUM_CORES(NC)) bus ();

  snoop_req_dispatcher #(.NUM_CORES(NC), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Upstream FIFO with registered output: data appears the cycle after the pop.
  logic [3:0] fmem [16];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [3:0] fdata = '0;

  always @(posedge clk) begin
    if (bus.fifo_rd_en && rd_ptr != wr_ptr) begin
      fdata  <= fmem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
  end
  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  assign bus.fifo_data  = fdata;

  task automatic push(input int core, input int op);
    bus_req_t r;
    r.core_id = 2'(core);
    r.op      = bus_op_e'(op);
    fmem[wr_ptr % 16] = r;
    wr_ptr++;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] s, input logic [3:0] d);
    bus.snoop_ready  = r;
    bus.snoop_shared = s;
    bus.snoop_dirty  = d;
  endtask

  function automatic logic [12:0] outs();
    return {bus.fifo_rd_en, bus.snoop_valid, bus.snoop_op, bus.resp_valid, bus.resp_core,
            bus.resp_shared, bus.resp_dirty, bus.busy};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(4'h0, 4'h0, 4'h0);
    bus.resp_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (outs() !== 13'h0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", outs()); end
`ifdef SNOOP_TIMEOUT_EN
    n_checks++; if (bus.resp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b want=0", bus.resp_timeout); end
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (outs() !== 13'h0) begin n_fail++; $display("FAIL idle_outputs got=%h want=0", outs()); end
  endtask

  task automatic test_basic_rd();
    int p0 = rd_ptr;
    push(1, 0);
    @(negedge clk);
    n_checks++; if (bus.fifo_rd_en !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL rd_pop got=%b%b want=11", bus.fifo_rd_en, bus.busy); end
    @(negedge clk);
    n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rd_pop_pulse got=%b want=0", bus.fifo_rd_en); end
    @(negedge clk);
    n_checks++; if (bus.snoop_valid !== 4'b1101 || bus.snoop_op !== 2'b00) begin n_fail++; $display("FAIL rd_snoop got=%b/%b want=1101/00", bus.snoop_valid, bus.snoop_op); end
    drive(4'b0001, 4'b0000, 4'b0000); @(negedge clk);
    n_checks++; if (bus.snoop_valid !== 4'b1100 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_step1 got=%b/%b want=1100/0", bus.snoop_valid, bus.resp_valid); end
    drive(4'b0100, 4'b0100, 4'b0000); @(negedge clk);
    n_checks++; if (bus.snoop_valid !== 4'b1000) begin n_fail++; $display("FAIL rd_step2 got=%b want=1000", bus.snoop_valid); end
    drive(4'b1000, 4'b0000, 4'b0000); @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0000);
    n_checks++; if ({bus.resp_valid, bus.resp_core, bus.resp_shared, bus.resp_dirty, bus.snoop_valid} !== 9'b1_01_1_0_0000) begin
      n_fail++; $display("FAIL rd_resp got=%b want=101100000", {bus.resp_valid, bus.resp_core, bus.resp_shared, bus.resp_dirty, bus.snoop_valid}); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_shared !== 1'b1) begin n_fail++; $display("FAIL rd_resp_hold got=%b%b want=11", bus.resp_valid, bus.resp_shared); end
    bus.resp_ack = 1'b1; @(negedge clk); bus.resp_ack = 1'b0;
    n_checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || rd_ptr - p0 !== 1) begin n_fail++; $display("FAIL rd_done got=%b%b pops=%0d want=00 pops=1", bus.resp_valid, bus.busy, rd_ptr - p0); end
  endtask

  task automatic test_upgr();
    push(3, 2);
    repeat (3) @(negedge clk);
    n_checks++; if (bus.snoop_valid !== 4'b0111 || bus.snoop_op !== 2'b10) begin n_fail++; $display("FAIL upgr_snoop got=%b/%b want=0111/10", bus.snoop_valid, bus.snoop_op); end
    drive(4'b0111, 4'b0000, 4'b0111); @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0000);
    n_checks++; if ({bus.resp_valid, bus.resp_core, bus.resp_shared, bus.resp_dirty} !== 5'b1_11_0_0) begin
      n_fail++; $display("FAIL upgr_resp got=%b want=11100", {bus.resp_valid, bus.resp_core, bus.resp_shared, bus.resp_dirty}); end
    bus.resp_ack = 1'b1; @(negedge clk); bus.resp_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back_flush();
    push(0, 3);
    push(1, 3);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++; if (bus.snoop_valid !== 4'b0000 || bus.resp_valid !== (c == 3)) begin
        n_fail++; $display("FAIL flush_c%0d got=%b/%b want=0000/%b", c, bus.snoop_valid, bus.resp_valid, c == 3); end
    end
    n_checks++; if ({bus.resp_core, bus.resp_shared, bus.resp_dirty} !== 4'b00_0_0) begin n_fail++; $display("FAIL flush_resp got=%b want=0000", {bus.resp_core, bus.resp_shared, bus.resp_dirty}); end
    bus.resp_ack = 1'b1; @(negedge clk); bus.resp_ack = 1'b0;
    n_checks++; if (bus.fifo_rd_en !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b%b want=00", bus.fifo_rd_en, bus.busy); end
    @(negedge clk);
    n_checks++; if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL b2b_pop got=%b want=1", bus.fifo_rd_en); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_core !== 2'd1) begin n_fail++; $display("FAIL b2b_resp got=%b/%0d want=1/1", bus.resp_valid, bus.resp_core); end
    bus.resp_ack = 1'b1; @(negedge clk); bus.resp_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignored_ready();
    push(2, 1);
    repeat (3) @(negedge clk);
    n_checks++; if (bus.snoop_valid !== 4'b1011) begin n_fail++; $display("FAIL ign_snoop got=%b want=1011", bus.snoop_valid); end
    drive(4'b0001, 4'b0000, 4'b0000); @(negedge clk);
    drive(4'b0101, 4'b0101, 4'b0101);
    bus.resp_ack = 1'b1;
    repeat (2) @(negedge clk);
    bus.resp_ack = 1'b0;
    n_checks++; if (bus.snoop_valid !== 4'b1010 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL ign_pending got=%b/%b want=1010/0", bus.snoop_valid, bus.resp_valid); end
    drive(4'b1010, 4'b0000, 4'b0000); @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0000);
    n_checks++; if ({bus.resp_valid, bus.resp_core, bus.resp_shared, bus.resp_dirty} !== 5'b1_10_0_0) begin
      n_fail++; $display("FAIL ign_resp got=%b want=11000", {bus.resp_valid, bus.resp_core, bus.resp_shared, bus.resp_dirty}); end
    bus.resp_ack = 1'b1; @(negedge clk); bus.resp_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    push(0, 0);
    repeat (3) @(negedge clk);
    drive(4'b1000, 4'b0000, 4'b0000); @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0000);
    n_checks++; if (bus.snoop_valid !== 4'b0110) begin n_fail++; $display("FAIL mid_pending got=%b want=0110", bus.snoop_valid); end
    rst = 1'b1; #1;
    n_checks++; if (outs() !== 13'h0) begin n_fail++; $display("FAIL mid_reset got=%h want=0", outs()); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    push(1, 1);
    @(negedge clk);
    n_checks++; if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL mid_repop got=%b want=1", bus.fifo_rd_en); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.snoop_valid !== 4'b1101 || bus.snoop_op !== 2'b01) begin n_fail++; $display("FAIL mid_snoop got=%b/%b want=1101/01", bus.snoop_valid, bus.snoop_op); end
    drive(4'b1101, 4'b0000, 4'b0100); @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0000);
    n_checks++; if ({bus.resp_valid, bus.resp_shared, bus.resp_dirty} !== 3'b101) begin n_fail++; $display("FAIL mid_resp got=%b want=101", {bus.resp_valid, bus.resp_shared, bus.resp_dirty}); end
    bus.resp_ack = 1'b1; @(negedge clk); bus.resp_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int         core;
      int         op;
      int         p0;
      bit         pend [NC];
      bit         esh;
      bit         edr;
      logic [3:0] emask;
      logic [3:0] r, s, d;
      core = $urandom_range(0, NC - 1);
      op   = $urandom_range(0, 3);
      p0   = rd_ptr;
      esh  = 1'b0;
      edr  = 1'b0;
      emask = '0;
      for (int i = 0; i < NC; i++) begin
        pend[i]  = (op != 3) && (i != core);
        emask[i] = pend[i];
      end
      push(core, op);
      @(negedge clk);
      n_checks++; if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_pop got=%b want=1", t, bus.fifo_rd_en); end
      repeat (2) @(negedge clk);
      if (op != 3) begin
        n_checks++; if (bus.snoop_valid !== emask || bus.snoop_op !== 2'(op)) begin
          n_fail++; $display("FAIL rnd%0d_snoop got=%b/%0d want=%b/%0d", t, bus.snoop_valid, bus.snoop_op, emask, op); end
        for (int c = 0; c < 40 && emask != 0; c++) begin
          r = 4'($urandom); s = 4'($urandom); d = 4'($urandom);
          if (c >= 8) r = 4'hF;
          for (int i = 0; i < NC; i++) begin
            if (pend[i] && r[i]) begin
              pend[i] = 1'b0;
              esh     = esh | s[i];
              if (op != 2) edr = edr | d[i];
            end
            emask[i] = pend[i];
          end
          drive(r, s, d);
          @(negedge clk);
          if (emask != 0) begin
            n_checks++; if (bus.snoop_valid !== emask || bus.resp_valid !== 1'b0) begin
              n_fail++; $display("FAIL rnd%0d_pend got=%b/%b want=%b/0", t, bus.snoop_valid, bus.resp_valid, emask); end
          end
        end
        drive(4'h0, 4'h0, 4'h0);
      end
      n_checks++; if ({bus.resp_valid, bus.resp_core, bus.resp_shared, bus.resp_dirty, bus.snoop_valid} !== {1'b1, 2'(core), esh, edr, 4'b0000}) begin
        n_fail++; $display("FAIL rnd%0d_resp got=%b want=%b", t, {bus.resp_valid, bus.resp_core, bus.resp_shared, bus.resp_dirty}, {1'b1, 2'(core), esh, edr}); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_shared !== esh || bus.resp_dirty !== edr) begin
        n_fail++; $display("FAIL rnd%0d_hold got=%b%b%b want=1%b%b", t, bus.resp_valid, bus.resp_shared, bus.resp_dirty, esh, edr); end
      bus.resp_ack = 1'b1; @(negedge clk); bus.resp_ack = 1'b0;
      n_checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || rd_ptr - p0 !== 1) begin
        n_fail++; $display("FAIL rnd%0d_done got=%b%b pops=%0d want=00 pops=1", t, bus.resp_valid, bus.busy, rd_ptr - p0); end
    end
  endtask

`ifdef SNOOP_TIMEOUT_EN
  task automatic test_timeout();
    push(0, 0);
    repeat (3) @(negedge clk);
    drive(4'b1010, 4'b0010, 4'b1000); @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0000);
    repeat (13) @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b0 || bus.snoop_valid !== 4'b0100) begin n_fail++; $display("FAIL to_wait got=%b/%b want=0/0100", bus.resp_valid, bus.snoop_valid); end
    @(negedge clk);
    n_checks++; if ({bus.resp_valid, bus.resp_timeout, bus.resp_shared, bus.resp_dirty, bus.snoop_valid} !== 8'b1111_0000) begin
      n_fail++; $display("FAIL to_resp got=%b want=11110000", {bus.resp_valid, bus.resp_timeout, bus.resp_shared, bus.resp_dirty, bus.snoop_valid}); end
    bus.resp_ack = 1'b1; @(negedge clk); bus.resp_ack = 1'b0;
    n_checks++; if (bus.resp_timeout !== 1'b0 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL to_clear got=%b%b want=00", bus.resp_timeout, bus.resp_valid); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_rd();
    test_upgr();
    test_back_to_back_flush();
    test_ignored_ready();
    test_reset_mid();
`ifdef SNOOP_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1);
  end

endmodule
